mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum mem_rdy wait cycles in any memory state before fault.
REQ-002 The block SHALL have port clk, input, 1, the single system clock, with all state changing on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port opcode, input, 6, the instruction-register opcode field.
REQ-005 The block SHALL have port funct, input, 6, the instruction-register funct field.
REQ-006 The block SHALL have port zero, input, 1, the ALU zero flag.
REQ-007 The block SHALL have port mem_rdy, input, 1, the memory access-complete strobe.
REQ-008 The block SHALL have output ports ir_wr, pc_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src and ext_sel, each 1 bit, as datapath enables and selects.
REQ-009 The block SHALL have output ports pc_src and alu_op, each 2 bits, as datapath select codes.
REQ-010 The block SHALL have output port state, 3 bits, the current FSM state code.
REQ-011 The block SHALL have output port err, 1 bit, a sticky fault flag.

Function
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=7.
- state SHALL always equal the current state code.
REQ-013 All outputs SHALL be Moore outputs decoded from state, a latched opcode copy and the wait counter; no output SHALL depend combinationally on mem_rdy, except as required by REQ-015.
REQ-014 In FETCH, mem_rd SHALL be 1.
- While mem_rdy=0: remain in FETCH and increment the 4-bit-minimum wait counter.
- On mem_rdy=1: in that same cycle assert ir_wr=1 and pc_wr=1 with pc_src=00 (PC+4), clear the counter and go to DECODE.
REQ-015 ir_wr SHALL be asserted in exactly one cycle per instruction, namely the FETCH cycle in which mem_rdy=1; ir_wr=mem_rdy gated by state==FETCH is permitted.
REQ-016 In DECODE the block SHALL classify opcode, with all other opcodes going to HALT with err=1:
- 000000 is R-type.
- 001001 is ADDIU.
- 100011 is LW.
- 101011 is SW.
- 000100 is BEQ.
- 000010 is J.
REQ-017 In DECODE, J SHALL assert pc_wr=1 with pc_src=10 and return to FETCH; all other legal opcodes SHALL go to EXEC.
REQ-018 For R-type in DECODE, funct SHALL be checked against the set 100001, 100011, 100100, 100101 and 101010; any other funct SHALL go to HALT with err=1.
REQ-019 In EXEC, alu_op, alu_src and ext_sel SHALL be set per class:
- R-type: alu_op=10, alu_src=0.
- ADDIU, LW, SW: alu_op=00, alu_src=1, ext_sel=1 (sign extend).
- BEQ: alu_op=01, alu_src=0.
REQ-020 EXEC SHALL transition as follows:
- R-type and ADDIU go to WB.
- LW and SW go to MEM.
- BEQ asserts pc_wr=zero with pc_src=01, then goes to FETCH.
REQ-021 In MEM, mem_rd=1 for LW and mem_wr=1 for SW, held until mem_rdy=1 using the same wait counter.
- LW then goes to WB.
- SW then goes to FETCH.
REQ-022 In WB, reg_wr SHALL be 1 for exactly one cycle, followed by FETCH.
- reg_dst=1 for R-type, otherwise 0.
- mem_to_reg=1 for LW, otherwise 0.
REQ-023 If the wait counter reaches WAIT_MAX in FETCH or MEM without mem_rdy, the FSM SHALL go to HALT and set err=1.
REQ-024 HALT SHALL be absorbing: all enables are 0 and only rst exits it.
REQ-025 The block SHALL latch opcode into an internal copy in DECODE, and all later states SHALL decode from that copy.
REQ-026 Outside the state in which they are active, all enables SHALL be 0.
- pc_wr and reg_wr SHALL never be asserted in the same cycle.
- mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-027 A mem_rdy=1 arriving on the same cycle the counter reaches WAIT_MAX SHALL count as success, with no fault.

Reset
REQ-028 While rst=1, asynchronously and regardless of clk, the block SHALL hold state=FETCH, err=0, wait counter=0, latched opcode=0, all enables=0 and all selects=0.
REQ-029 When rst deasserts, mem_rd=1 SHALL be issued from the first rising edge.
REQ-030 rst asserted mid-instruction (any state, including a MEM write) SHALL abort it immediately with mem_wr dropping asynchronously, and no partial reg_wr or pc_wr SHALL occur.

Verification
REQ-031 Scenario: mem_rdy always 1, opcode=000000, funct=100001 -> state sequence 0,1,2,4,0; ir_wr pulses once, reg_wr pulses once with reg_dst=1.
REQ-032 Scenario: LW with mem_rdy=0 for 3 cycles in MEM -> mem_rd held 4 cycles, then WB with mem_to_reg=1; total 8 cycles, no err.
REQ-033 Scenario: BEQ with zero=1, then zero=0 -> pc_wr=1 and pc_src=01 in EXEC for the first; pc_wr=0 in EXEC for the second; both return to FETCH.
REQ-034 Scenario: opcode=111111 -> HALT with err=1, and HALT persists for 20 cycles despite mem_rdy toggling.
REQ-035 Scenario: mem_rdy=0 in FETCH for 15 cycles -> HALT, err=1; mem_rdy=1 at exactly cycle 15 -> DECODE, no err.
REQ-036 Scenario: rst pulsed during SW in MEM -> mem_wr falls without waiting for a clock edge, state=0, and the next cycles refetch.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a bounded mem_rdy wait and a sticky, reset-only HALT on any fault.
module mc_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       ext_sel,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic [2:0] state,
    output logic       err
);

    localparam int CW_RAW = $clog2(WAIT_MAX + 1);
    localparam int CW     = (CW_RAW > 4) ? CW_RAW : 4;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t          r_state;
    logic            r_run;
    logic [CW-1:0]   r_wait;
    logic [5:0]      r_opcode;
    logic            r_err;

    logic w_op_legal;
    logic w_funct_legal;
    logic w_decode_bad;
    logic w_wait_expired;

    assign w_op_legal     = opcode inside {OP_R, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J};
    assign w_funct_legal  = funct inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
    assign w_decode_bad   = !w_op_legal || ((opcode == OP_R) && !w_funct_legal);
    // This cycle is the WAIT_MAX-th consecutive one without mem_rdy.
    assign w_wait_expired = (r_wait >= WAIT_LAST);

    // r_run holds the machine idle until the first rising edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_opcode <= '0;
            r_err    <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_rdy) begin
                        r_wait  <= '0;
                        r_state <= S_DECODE;
                    end else if (w_wait_expired) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_opcode <= opcode;
                    if (w_decode_bad) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else if (opcode == OP_J) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OP_R, OP_ADDIU: r_state <= S_WB;
                        OP_LW, OP_SW:   r_state <= S_MEM;
                        default:        r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_rdy) begin
                        r_wait  <= '0;
                        r_state <= (r_opcode == OP_LW) ? S_WB : S_FETCH;
                    end else if (w_wait_expired) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: begin
                    r_state <= S_HALT;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    // Gating by rst makes every enable, including mem_wr, drop without a clock edge.
    always_comb begin
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        ext_sel    = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        if (!rst && r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    ir_wr  = mem_rdy;
                    pc_wr  = mem_rdy;
                end
                S_DECODE: begin
                    if (!w_decode_bad && (opcode == OP_J)) begin
                        pc_wr  = 1'b1;
                        pc_src = 2'b10;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OP_R:   alu_op = 2'b10;
                        OP_BEQ: begin
                            alu_op = 2'b01;
                            pc_src = 2'b01;
                            pc_wr  = zero;
                        end
                        default: begin
                            alu_op  = 2'b00;
                            alu_src = 1'b1;
                            ext_sel = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_rd = (r_opcode == OP_LW);
                    mem_wr = (r_opcode == OP_SW);
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    reg_dst    = (r_opcode == OP_R);
                    mem_to_reg = (r_opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;
    assign err   = r_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: an instruction-level model pushes per-cycle
// expected outputs into a scoreboard that a negedge monitor drains.
module tb_mc_ctrl;
    localparam int WAIT_MAX = 15;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_rdy;
    logic       ir_wr, pc_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src, ext_sel;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;
    logic       err;

    mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_sel(ext_sel),
        .pc_src(pc_src), .alu_op(alu_op), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       err;
        logic       ir, pcw, mrd, mwr, rwr, rdst, m2r, asrc, ext;
        logic [1:0] pcsrc, aluop;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   halted   = 1'b0;

    logic [5:0] legal_ops [6] = '{OP_R, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J};
    logic [5:0] legal_fns [5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};

    function automatic bit in_ops(input logic [5:0] v);
        foreach (legal_ops[i]) if (legal_ops[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_fns(input logic [5:0] v);
        foreach (legal_fns[i]) if (legal_fns[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st = state; a.err = err; a.ir = ir_wr; a.pcw = pc_wr; a.mrd = mem_rd; a.mwr = mem_wr;
        a.rwr = reg_wr; a.rdst = reg_dst; a.m2r = mem_to_reg; a.asrc = alu_src; a.ext = ext_sel;
        a.pcsrc = pc_src; a.aluop = alu_op;
        return a;
    endfunction

    function automatic exp_t halt_exp();
        exp_t x = '0;
        x.st  = 3'd7;
        x.err = 1'b1;
        return x;
    endfunction

    task automatic check_now(input string name, input exp_t want);
        exp_t act = sample();
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s act=%h exp=%h (state act %0d exp %0d)", name, act, want, act.st, want.st);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t want, act;
        if (!rst && sb.size() > 0) begin
            want = sb.pop_front();
            act  = sample();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t act=%h exp=%h (state act %0d exp %0d)",
                         $time, act, want, act.st, want.st);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic z, input exp_t x);
        mem_rdy = rdy;
        zero    = z;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) cyc(rb(), rb(), halt_exp());
    endtask

    task automatic do_reset();
        exp_t x = '0;
        rst    = 1'b1;
        halted = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", x);
        rst = 1'b0;
        cyc(rb(), rb(), x);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input bit abort);
        exp_t x;
        $display("TXN op=%b funct=%b zero=%0b fetch_wait=%0d mem_wait=%0d abort=%0b",
                 op, fn, z, fw, mw, abort);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < fw; i++) begin
            x = '0; x.mrd = 1'b1;
            cyc(1'b0, rb(), x);
            if (i + 1 == WAIT_MAX) begin halted = 1'b1; return; end
        end
        x = '0; x.mrd = 1'b1; x.ir = 1'b1; x.pcw = 1'b1;
        cyc(1'b1, rb(), x);

        x = '0; x.st = 3'd1;
        if (!in_ops(op) || (op == OP_R && !in_fns(fn))) begin
            cyc(rb(), rb(), x);
            halted = 1'b1;
            return;
        end
        if (op == OP_J) begin
            x.pcw = 1'b1; x.pcsrc = 2'b10;
            cyc(rb(), rb(), x);
            return;
        end
        cyc(rb(), rb(), x);
        // Later states must decode from the copy latched in DECODE.
        opcode = 6'($urandom);
        funct  = 6'($urandom);

        x = '0; x.st = 3'd2;
        if (op == OP_R) x.aluop = 2'b10;
        else if (op == OP_BEQ) begin x.aluop = 2'b01; x.pcsrc = 2'b01; x.pcw = z; end
        else begin x.asrc = 1'b1; x.ext = 1'b1; end
        cyc(rb(), z, x);
        if (op == OP_BEQ) return;

        if (op == OP_LW || op == OP_SW) begin
            x = '0; x.st = 3'd3; x.mrd = (op == OP_LW); x.mwr = (op == OP_SW);
            if (abort) begin
                mem_rdy = 1'b0;
                #1;
                check_now("mem_before_abort", x);
                rst = 1'b1;
                #1;
                x = '0;
                check_now("async_abort", x);
                return;
            end
            for (int i = 0; i < mw; i++) begin
                cyc(1'b0, rb(), x);
                if (i + 1 == WAIT_MAX) begin halted = 1'b1; return; end
            end
            cyc(1'b1, rb(), x);
            if (op == OP_SW) return;
        end

        x = '0; x.st = 3'd4; x.rwr = 1'b1; x.rdst = (op == OP_R); x.m2r = (op == OP_LW);
        cyc(rb(), rb(), x);
    endtask

    task automatic recover();
        if (halted) do_halt($urandom_range(2, 5));
        if (halted || rst) do_reset();
    endtask

    initial begin
        logic [5:0] op, fn;
        int k, r, fw, mw;
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(OP_R, 6'b100001, 1'b0, 0, 0, 1'b0);
        run_instr(OP_LW, 6'b000000, 1'b0, 0, 3, 1'b0);
        run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0, 1'b0);
        run_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0, 1'b0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        do_halt(20);
        recover();
        run_instr(OP_ADDIU, 6'b000000, 1'b0, WAIT_MAX, 0, 1'b0);
        recover();
        run_instr(OP_R, 6'b101010, 1'b0, WAIT_MAX - 1, 0, 1'b0);
        run_instr(OP_SW, 6'b000000, 1'b0, 1, 0, 1'b1);
        recover();
        run_instr(OP_J, 6'b111111, 1'b0, 2, 0, 1'b0);
        run_instr(OP_SW, 6'b000000, 1'b0, 0, WAIT_MAX, 1'b0);
        recover();
        run_instr(OP_LW, 6'b000000, 1'b0, 0, WAIT_MAX - 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) op = legal_ops[k];
            else if (k <= 7) op = legal_ops[$urandom_range(0, 5)];
            else if (k == 8) begin
                do op = 6'($urandom); while (in_ops(op));
            end else op = OP_R;
            if (k == 9) begin
                do fn = 6'($urandom); while (in_fns(fn));
            end else if (op == OP_R) fn = legal_fns[$urandom_range(0, 4)];
            else fn = 6'($urandom);
            r  = $urandom_range(0, 19);
            fw = (r < 16) ? r % 4 : ((r < 18) ? WAIT_MAX - 1 : WAIT_MAX);
            r  = $urandom_range(0, 19);
            mw = (r < 16) ? r % 4 : ((r < 18) ? WAIT_MAX - 1 : WAIT_MAX);
            run_instr(op, fn, rb(), fw, mw, ($urandom_range(0, 9) == 0));
            recover();
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
